// File: rtl/regfile_mp.sv
// Multi-port integer register file with a per-register busy scoreboard.
// x0 is hardwired to zero; reads and read-busy flags are combinational, with optional write bypass.
module regfile_mp #(
    parameter int unsigned NumRegs       = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned NumReadPorts  = 4,
    parameter int unsigned NumWritePorts = 2,
    parameter bit          BypassEn      = 1'b1,
    localparam int unsigned AddressWidth = $clog2(NumRegs)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NumWritePorts-1:0]               wr_en_i,
    input  logic [NumWritePorts*AddressWidth-1:0]  wr_addr_i,
    input  logic [NumWritePorts*DataWidth-1:0]     wr_data_i,
    input  logic [NumReadPorts*AddressWidth-1:0]   rd_addr_i,
    output logic [NumReadPorts*DataWidth-1:0]      rd_data_o,
    output logic [NumReadPorts-1:0]                rd_busy_o,
    input  logic                                   issue_en_i,
    input  logic [AddressWidth-1:0]                issue_addr_i,
    output logic [NumRegs-1:0]                     busy_o
);

    logic [DataWidth-1:0]    regs_q [NumRegs];
    logic [NumRegs-1:0]      busy_q;
    logic [NumRegs-1:0]      busy_d;
    logic [NumRegs-1:0]      wr_hit;
    logic [DataWidth-1:0]    wr_val [NumRegs];
    logic [AddressWidth-1:0] wr_addr [NumWritePorts];
    logic [AddressWidth-1:0] rd_addr [NumReadPorts];

    always_comb begin
        for (int unsigned p = 0; p < NumWritePorts; p++) begin
            wr_addr[p] = wr_addr_i[p*AddressWidth +: AddressWidth];
        end
        for (int unsigned r = 0; r < NumReadPorts; r++) begin
            rd_addr[r] = rd_addr_i[r*AddressWidth +: AddressWidth];
        end
    end

    // Per-register write resolution; later (higher-index) ports overwrite earlier ones.
    always_comb begin
        wr_hit = '0;
        for (int unsigned k = 0; k < NumRegs; k++) begin
            wr_val[k] = '0;
        end
        for (int unsigned p = 0; p < NumWritePorts; p++) begin
            if (wr_en_i[p] && (wr_addr[p] != '0)) begin
                wr_hit[wr_addr[p]] = 1'b1;
                wr_val[wr_addr[p]] = wr_data_i[p*DataWidth +: DataWidth];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < NumRegs; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 1; k < NumRegs; k++) begin
                if (wr_hit[k]) begin
                    regs_q[k] <= wr_val[k];
                end
            end
        end
    end

    // A new issue outranks a writeback to the same register in the same cycle.
    always_comb begin
        busy_d = busy_q & ~wr_hit;
        if (issue_en_i && (issue_addr_i != '0)) begin
            busy_d[issue_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int unsigned r = 0; r < NumReadPorts; r++) begin
            if (rd_addr[r] != '0) begin
                if (BypassEn && !rst_i && wr_hit[rd_addr[r]]) begin
                    rd_data_o[r*DataWidth +: DataWidth] = wr_val[rd_addr[r]];
                end else begin
                    rd_data_o[r*DataWidth +: DataWidth] = regs_q[rd_addr[r]];
                    rd_busy_o[r]                        = busy_q[rd_addr[r]];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios then random traffic, checked against an array model.
module tb_regfile_mp;
    localparam int NR  = 32;
    localparam int DW  = 32;
    localparam int NRP = 4;
    localparam int NWP = 2;
    localparam int AW  = 5;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                rst_i;
    logic [NWP-1:0]      wr_en;
    logic [NWP*AW-1:0]   wr_addr;
    logic [NWP*DW-1:0]   wr_data;
    logic [NRP*AW-1:0]   rd_addr;
    logic [NRP*DW-1:0]   rd_data, rd_data_nb;
    logic [NRP-1:0]      rd_busy, rd_busy_nb;
    logic                issue_en;
    logic [AW-1:0]       issue_addr;
    logic [NR-1:0]       busy_o, busy_o_nb;

    regfile_mp #(.NumRegs(NR), .DataWidth(DW), .NumReadPorts(NRP), .NumWritePorts(NWP), .BypassEn(1'b1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
        .issue_en_i(issue_en), .issue_addr_i(issue_addr), .busy_o(busy_o));

    regfile_mp #(.NumRegs(NR), .DataWidth(DW), .NumReadPorts(NRP), .NumWritePorts(NWP), .BypassEn(1'b0)) dut_nb (
        .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data_nb), .rd_busy_o(rd_busy_nb),
        .issue_en_i(issue_en), .issue_addr_i(issue_addr), .busy_o(busy_o_nb));

    // Architectural model
    logic [DW-1:0] m_regs [NR];
    bit            m_busy [NR];
    bit            model_valid = 1'b0;
    int            tests = 0;
    int            fails = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic set_wr(input int p, input bit en, input int a, input logic [DW-1:0] d);
        wr_en[p]            = en;
        wr_addr[p*AW +: AW] = AW'(a);
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic set_rd(input int r, input int a);
        rd_addr[r*AW +: AW] = AW'(a);
    endtask

    task automatic idle();
        rst_i      = 1'b0;
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        issue_en   = 1'b0;
        issue_addr = '0;
    endtask

    // Expected read for address a, given the currently driven inputs.
    task automatic exp_read(input int a, input bit byp, output logic [DW-1:0] d, output logic b);
        bit hit = 1'b0;
        logic [DW-1:0] hv = '0;
        for (int p = 0; p < NWP; p++) begin
            if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == a) begin
                hit = 1'b1;
                hv  = wr_data[p*DW +: DW];
            end
        end
        if (a == 0) begin
            d = '0; b = 1'b0;
        end else if (byp && !rst_i && hit) begin
            d = hv; b = 1'b0;
        end else begin
            d = m_regs[a]; b = m_busy[a];
        end
    endtask

    task automatic settle();
        logic [DW-1:0] ed;
        logic          eb;
        #1;
        if (model_valid) begin
            for (int r = 0; r < NRP; r++) begin
                exp_read(int'(rd_addr[r*AW +: AW]), 1'b1, ed, eb);
                check("rd_data_byp", rd_data[r*DW +: DW], ed);
                check("rd_busy_byp", {31'b0, rd_busy[r]}, {31'b0, eb});
                exp_read(int'(rd_addr[r*AW +: AW]), 1'b0, ed, eb);
                check("rd_data_nobyp", rd_data_nb[r*DW +: DW], ed);
                check("rd_busy_nobyp", {31'b0, rd_busy_nb[r]}, {31'b0, eb});
            end
        end
    endtask

    task automatic edge_step();
        logic [NR-1:0] eb;
        @(posedge clk_i);
        if (rst_i) begin
            for (int k = 0; k < NR; k++) begin
                m_regs[k] = '0;
                m_busy[k] = 1'b0;
            end
        end else begin
            for (int p = 0; p < NWP; p++) begin
                int a = int'(wr_addr[p*AW +: AW]);
                if (wr_en[p] && a != 0) begin
                    m_regs[a] = wr_data[p*DW +: DW];
                    m_busy[a] = 1'b0;
                end
            end
            if (issue_en && issue_addr != '0) m_busy[int'(issue_addr)] = 1'b1;
        end
        if (rst_i) model_valid = 1'b1;
        #1;
        if (model_valid) begin
            for (int k = 0; k < NR; k++) eb[k] = m_busy[k];
            check("busy_o", busy_o, eb);
            check("busy_o_nobyp", busy_o_nb, eb);
        end
    endtask

    task automatic cycle();
        settle();
        edge_step();
    endtask

    initial begin
        idle();
        rd_addr = '0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        cycle();
        idle();

        // 1: fill with ones, issue a few, then reset while still writing ones
        for (int k = 0; k < NR; k += 2) begin
            set_wr(0, 1'b1, k, 32'hFFFF_FFFF);
            set_wr(1, 1'b1, k + 1, 32'hFFFF_FFFF);
            issue_en = 1'b1; issue_addr = AW'(k + 1);
            cycle();
        end
        rst_i = 1'b1;
        set_wr(0, 1'b1, 4, 32'hFFFF_FFFF);
        set_wr(1, 1'b1, 8, 32'hFFFF_FFFF);
        issue_en = 1'b1; issue_addr = AW'(12);
        cycle();
        check("reset_busy_o", busy_o, 32'h0);
        idle();
        for (int k = 0; k < NR; k += NRP) begin
            for (int r = 0; r < NRP; r++) set_rd(r, k + r);
            settle();
            for (int r = 0; r < NRP; r++) check("reset_rd", rd_data[r*DW +: DW], 32'h0);
            check("reset_rd_busy", {28'b0, rd_busy}, 32'h0);
            edge_step();
        end

        // 2: x0 ignores writes and issues
        set_wr(0, 1'b1, 0, 32'h1234);
        issue_en = 1'b1; issue_addr = '0;
        set_rd(0, 0);
        cycle();
        idle();
        settle();
        check("x0_read", rd_data[DW-1:0], 32'h0);
        check("x0_busy", {31'b0, busy_o[0]}, 32'h0);
        edge_step();

        // 3: write conflict, highest port wins
        set_wr(0, 1'b1, 5, 32'hAAAA);
        set_wr(1, 1'b1, 5, 32'h5555);
        cycle();
        idle();
        set_rd(1, 5);
        settle();
        check("conflict_r5", rd_data[DW +: DW], 32'h5555);
        edge_step();

        // 4: bypass vs no bypass
        set_wr(0, 1'b1, 7, 32'h11);
        cycle();
        set_wr(0, 1'b1, 7, 32'h22);
        set_rd(0, 7);
        settle();
        check("bypass_on", rd_data[DW-1:0], 32'h22);
        check("bypass_off", rd_data_nb[DW-1:0], 32'h11);
        edge_step();
        idle();

        // 5: scoreboard set/clear/simultaneous
        issue_en = 1'b1; issue_addr = AW'(3);
        cycle();
        idle();
        set_rd(2, 3);
        settle();
        check("sb_busy3_set", {31'b0, busy_o[3]}, 32'h1);
        check("sb_rd_busy3", {31'b0, rd_busy[2]}, 32'h1);
        edge_step();
        set_wr(1, 1'b1, 3, 32'h99);
        cycle();
        idle();
        check("sb_busy3_clr", {31'b0, busy_o[3]}, 32'h0);
        issue_en = 1'b1; issue_addr = AW'(3);
        set_wr(0, 1'b1, 3, 32'h123);
        cycle();
        check("sb_issue_wins", {31'b0, busy_o[3]}, 32'h1);
        idle();

        // 6: reset discards same-cycle issue and write
        set_wr(0, 1'b1, 9, 32'h77);
        cycle();
        idle();
        rst_i = 1'b1;
        issue_en = 1'b1; issue_addr = AW'(9);
        set_wr(1, 1'b1, 9, 32'h77);
        cycle();
        idle();
        set_rd(3, 9);
        settle();
        check("rstmid_r9", rd_data[3*DW +: DW], 32'h0);
        check("rstmid_busy9", {31'b0, busy_o[9]}, 32'h0);
        edge_step();

        // Random traffic, addresses biased low to provoke conflicts and bypass hits
        for (int i = 0; i < 400; i++) begin
            rst_i = ($urandom_range(0, 39) == 0);
            for (int p = 0; p < NWP; p++)
                set_wr(p, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, NR - 1)),
                       $urandom);
            for (int r = 0; r < NRP; r++)
                set_rd(r, ($urandom_range(0, 2) == 0) ? int'(wr_addr[($urandom_range(0, NWP - 1))*AW +: AW])
                                                     : int'($urandom_range(0, 7)));
            issue_en   = 1'($urandom_range(0, 1));
            issue_addr = AW'($urandom_range(0, 7));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
